// File: rtl/uart_tx_arbiter_if.sv
// Requester / uart_tx handshake bundle for uart_tx_arbiter.
// master: the arbiter side. slave: requesters plus the uart_tx core.
// Optional macro UART_ARB_TIMEOUT_EN adds the timeout_pulse signal.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 2
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_data_valid;
   logic                 tx_data_ready;
   logic [GW-1:0]        grant_id;
   logic                 busy;
`ifdef UART_ARB_TIMEOUT_EN
   logic                 timeout_pulse;

   modport master (
      input  req_valid, req_data, req_last, tx_data_ready,
      output req_ready, tx_data, tx_data_valid, grant_id, busy, timeout_pulse
   );
   modport slave (
      output req_valid, req_data, req_last, tx_data_ready,
      input  req_ready, tx_data, tx_data_valid, grant_id, busy, timeout_pulse
   );
`else
   modport master (
      input  req_valid, req_data, req_last, tx_data_ready,
      output req_ready, tx_data, tx_data_valid, grant_id, busy
   );
   modport slave (
      output req_valid, req_data, req_last, tx_data_ready,
      input  req_ready, tx_data, tx_data_valid, grant_id, busy
   );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx byte transmitter between NUM_REQ
// byte-stream requesters. Round-robin grant, held until a byte flagged
// last has been sent, so frames from different sources never interleave.
// Optional macro UART_ARB_TIMEOUT_EN: revoke a grant whose owner stays
// idle for TIMEOUT_CYCLES cycles in LOCKED, and pulse timeout_pulse.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   uart_tx_arbiter_if.master bus
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOCKED,
      S_SEND,
      S_DRAIN
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [GW-1:0] r_grant;
   logic [GW-1:0] r_rr_ptr;
   logic [7:0]    r_tx_data;
   logic          r_tx_valid;
   logic          r_last_q;

   logic [GW-1:0] w_winner;
   logic          w_found;
   logic [GW-1:0] w_grant_inc;
   logic          w_owner_valid;
   logic [7:0]    w_owner_data;
   logic          w_owner_last;
   logic          w_accept;
   logic          w_timeout;

   // Owner's request lines, muxed by the current grant
   always_comb begin
      w_owner_valid = 1'b0;
      w_owner_data  = 8'h00;
      w_owner_last  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant == GW'(i)) begin
            w_owner_valid = bus.req_valid[i];
            w_owner_data  = bus.req_data[8*i +: 8];
            w_owner_last  = bus.req_last[i];
         end
      end
   end

   // Round-robin search: lowest valid index at or above rr_ptr, else lowest below it
   always_comb begin
      w_winner = '0;
      w_found  = |bus.req_valid;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i] && (i < int'(r_rr_ptr))) begin
            w_winner = GW'(i);
         end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i] && (i >= int'(r_rr_ptr))) begin
            w_winner = GW'(i);
         end
      end
   end

   // Explicit wrap so non-power-of-two NUM_REQ returns to 0 after NUM_REQ-1
   assign w_grant_inc = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

   // The ~tx_valid term guarantees a single byte in flight
   assign w_accept = (r_state == S_LOCKED) && w_owner_valid &&
                     bus.tx_data_ready && !r_tx_valid;

   // Only the owner ever sees ready, and only in the accepting cycle
   always_comb begin
      bus.req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_accept && (r_grant == GW'(i))) begin
            bus.req_ready[i] = 1'b1;
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CW-1:0] r_to_cnt;
   logic          r_timeout_pulse;

   assign w_timeout = (r_state == S_LOCKED) && !w_owner_valid &&
                      (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Idle-owner counter; cleared by acceptance, any state change or owner activity
   always_ff @(posedge clk) begin
      if (rst) begin
         r_to_cnt        <= '0;
         r_timeout_pulse <= 1'b0;
      end else begin
         r_timeout_pulse <= w_timeout;
         if ((r_state != S_LOCKED) || w_owner_valid || w_timeout) begin
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
      end
   end

   assign bus.timeout_pulse = r_timeout_pulse;
`else
   // No timer in this build: a stalled owner keeps the UART indefinitely
   assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_found) w_state_nxt = S_LOCKED;
         end
         S_LOCKED: begin
            if (w_accept)       w_state_nxt = S_SEND;
            else if (w_timeout) w_state_nxt = S_IDLE;
         end
         S_SEND: begin
            if (!bus.tx_data_ready) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (bus.tx_data_ready) w_state_nxt = r_last_q ? S_IDLE : S_LOCKED;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Grant, round-robin pointer and the byte handed to uart_tx
   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant    <= '0;
         r_rr_ptr   <= '0;
         r_tx_data  <= 8'h00;
         r_tx_valid <= 1'b0;
         r_last_q   <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && w_found) begin
            r_grant <= w_winner;
         end
         if (w_accept) begin
            r_tx_data  <= w_owner_data;
            r_last_q   <= w_owner_last;
            r_tx_valid <= 1'b1;
         end
         if ((r_state == S_SEND) && !bus.tx_data_ready) begin
            r_tx_valid <= 1'b0;
         end
         if ((r_state == S_DRAIN) && bus.tx_data_ready && r_last_q) begin
            r_rr_ptr <= w_grant_inc;
         end
         if (w_timeout) begin
            r_rr_ptr <= w_grant_inc;
         end
      end
   end

   assign bus.tx_data       = r_tx_data;
   assign bus.tx_data_valid = r_tx_valid;
   assign bus.grant_id      = r_grant;
   assign bus.busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NUM_REQ=2). Requester drivers pull
// bytes from per-source queues; a uart_tx model drops ready for 10 cycles
// per byte; a monitor pops expected {grant, byte} pairs as bytes leave.
module tb_uart_tx_arbiter;
   localparam int NUM_REQ = 2;
`ifdef UART_ARB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic [7:0] gap;
   } src_t;

   typedef struct packed {
      logic [7:0] grant;
      logic [7:0] data;
   } exp_t;

   logic clk;
   logic rst;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   src_t srcq [NUM_REQ][$];
   exp_t expq [$];
   int   checks;
   int   errors;
   int   rdy_cnt [NUM_REQ];
   int   exp_rdy [NUM_REQ];
   int   to_pulses;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Requester drivers: advance on a sampled req_ready, honour per-entry gaps
   initial begin
      logic [NUM_REQ-1:0] rdy_s;
      src_t f;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      forever begin
         @(negedge clk);
         rdy_s = bus.req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rdy_s[i] && (srcq[i].size() > 0)) void'(srcq[i].pop_front());
            bus.req_valid[i] = 1'b0;
            bus.req_last[i]  = 1'b0;
            if (srcq[i].size() > 0) begin
               f = srcq[i][0];
               if (f.gap != 8'd0) begin
                  f.gap = f.gap - 8'd1;
                  srcq[i][0] = f;
               end else begin
                  bus.req_valid[i]        = 1'b1;
                  bus.req_data[8*i +: 8]  = f.data;
                  bus.req_last[i]         = f.last;
               end
            end
         end
      end
   end

   // uart_tx model: ready drops one cycle after a start, returns 10 cycles later
   initial begin
      bus.tx_data_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && bus.tx_data_valid && bus.tx_data_ready) begin
            @(posedge clk);
            #1 bus.tx_data_ready = 1'b0;
            repeat (10) @(posedge clk);
            #1 bus.tx_data_ready = 1'b1;
         end
      end
   end

   // Monitor: compare every started byte and every req_ready pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.tx_data_valid && bus.tx_data_ready) begin
               checks++;
               if (expq.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_byte: got grant=%0d data=%h, required none", bus.grant_id, bus.tx_data);
               end else begin
                  e = expq.pop_front();
                  if ((bus.tx_data !== e.data) || ({7'd0, bus.grant_id} !== e.grant)) begin
                     errors++;
                     $display("FAIL tx_byte: got grant=%0d data=%h, required grant=%0d data=%h",
                              bus.grant_id, bus.tx_data, e.grant, e.data);
                  end
               end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
               if (bus.req_ready[i]) begin
                  rdy_cnt[i]++;
                  checks++;
                  if (int'(bus.grant_id) != i) begin
                     errors++;
                     $display("FAIL ready_owner: req_ready[%0d] with grant_id=%0d, required grant_id=%0d", i, bus.grant_id, i);
                  end
               end
            end
`ifdef UART_ARB_TIMEOUT_EN
            if (bus.timeout_pulse) to_pulses++;
`endif
         end
      end
   end

   task automatic push_src(input int i, input logic [7:0] d, input logic l, input logic [7:0] gap);
      srcq[i].push_back('{data: d, last: l, gap: gap});
      exp_rdy[i]++;
   endtask

   task automatic push_exp(input int g, input logic [7:0] d);
      expq.push_back('{grant: 8'(g), data: d});
   endtask

   task automatic check_eq(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         srcq[i].delete();
         rdy_cnt[i] = 0;
         exp_rdy[i] = 0;
      end
      expq.delete();
      to_pulses = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; (c < 40) && !bus.tx_data_ready; c++) @(posedge clk);
   endtask

   task automatic wait_done(input string name);
      bit done;
      done = 1'b0;
      for (int c = 0; (c < 2000) && !done; c++) begin
         @(negedge clk);
         if ((expq.size() == 0) && !bus.busy && (srcq[0].size() == 0) && (srcq[1].size() == 0)) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_timeout: got %0d bytes outstanding, required 0", name, expq.size());
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         check_eq({name, "_ready_pulses"}, rdy_cnt[i], exp_rdy[i]);
         rdy_cnt[i] = 0;
         exp_rdy[i] = 0;
      end
   endtask

   initial begin
      bit seen;
      checks    = 0;
      errors    = 0;
      to_pulses = 0;
      rst       = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         rdy_cnt[i] = 0;
         exp_rdy[i] = 0;
      end
      do_reset();

      // Reset state
      @(negedge clk);
      check_eq("rst_valid", int'(bus.tx_data_valid), 0);
      check_eq("rst_busy", int'(bus.busy), 0);
      check_eq("rst_grant", int'(bus.grant_id), 0);
      check_eq("rst_data", int'(bus.tx_data), 0);
      check_eq("rst_ready", int'(bus.req_ready), 0);

      // Single source "OK\n"
      push_src(0, 8'h4F, 1'b0, 8'd0);
      push_src(0, 8'h4B, 1'b0, 8'd0);
      push_src(0, 8'h0A, 1'b1, 8'd0);
      push_exp(0, 8'h4F);
      push_exp(0, 8'h4B);
      push_exp(0, 8'h0A);
      wait_done("single");
      check_eq("single_busy", int'(bus.busy), 0);

      // rr_ptr is now 1: requester 1 must win a simultaneous request
      push_src(0, 8'h10, 1'b1, 8'd0);
      push_src(1, 8'h20, 1'b1, 8'd0);
      push_exp(1, 8'h20);
      push_exp(0, 8'h10);
      wait_done("rr_after_single");

      // Contention from reset: "AB" then "CD", no interleave
      do_reset();
      push_src(0, 8'h41, 1'b0, 8'd0);
      push_src(0, 8'h42, 1'b1, 8'd0);
      push_src(1, 8'h43, 1'b0, 8'd0);
      push_src(1, 8'h44, 1'b1, 8'd0);
      push_exp(0, 8'h41);
      push_exp(0, 8'h42);
      push_exp(1, 8'h43);
      push_exp(1, 8'h44);
      wait_done("contention");

      // Round-robin with single-byte frames
      do_reset();
      for (int k = 0; k < 4; k++) begin
         push_src(0, 8'(8'h60 + k), 1'b1, 8'd0);
         push_src(1, 8'(8'h70 + k), 1'b1, 8'd0);
         push_exp(0, 8'(8'h60 + k));
         push_exp(1, 8'(8'h70 + k));
      end
      wait_done("round_robin");

      // Owner stall mid-frame (with the timer, the grant is revoked instead)
      do_reset();
      push_src(0, 8'h41, 1'b0, 8'd0);
      push_src(0, 8'h42, 1'b1, 8'd50);
      push_src(1, 8'h5A, 1'b1, 8'd0);
      push_exp(0, 8'h41);
`ifdef UART_ARB_TIMEOUT_EN
      push_exp(1, 8'h5A);
      push_exp(0, 8'h42);
`else
      push_exp(0, 8'h42);
      push_exp(1, 8'h5A);
`endif
      wait_done("owner_stall");
`ifdef UART_ARB_TIMEOUT_EN
      check_eq("timeout_pulses", to_pulses, 1);
`endif

      // Reset while in SEND owned by requester 1
      do_reset();
      push_src(1, 8'h66, 1'b0, 8'd0);
      push_src(1, 8'h67, 1'b1, 8'd0);
      push_exp(1, 8'h66);
      seen = 1'b0;
      for (int c = 0; (c < 100) && !seen; c++) begin
         @(negedge clk);
         if (bus.tx_data_valid) seen = 1'b1;
      end
      check_eq("midrst_send_seen", int'(seen), 1);
      check_eq("midrst_grant_before", int'(bus.grant_id), 1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_valid", int'(bus.tx_data_valid), 0);
      check_eq("midrst_busy", int'(bus.busy), 0);
      check_eq("midrst_grant", int'(bus.grant_id), 0);
      check_eq("midrst_ready", int'(bus.req_ready), 0);
      check_eq("midrst_byte_seen", expq.size(), 0);
      do_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
